// File: rtl/uart_rx_ctrl_if.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl_if
// Processor-side bus of the UART receive controller: 4-bit port address,
// one-cycle read/write qualifiers, write data, combinational read data, and
// the interrupt request / acknowledge pair.
//   master : the processor (drives address, strobes, write data, ack)
//   slave  : uart_rx_ctrl (drives read data and the interrupt level)
// ---------------------------------------------------------------------------
interface uart_rx_ctrl_if;
    logic [3:0] port_id;
    logic       write_strobe;
    logic       read_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, write_strobe, read_strobe, out_port, interrupt_ack,
        output in_port, interrupt
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// uart_rx_ctrl
// Control / host-interface block for a UART receive engine.
//  - Holds the engine configuration (EIGHT, PEN, OHEL, BAUD); a CFG write is
//    staged in a pending register and only reaches the engine while it is
//    idle (rx_busy=0). IRQ_EN takes effect immediately.
//  - Buffers one received byte with sticky parity/framing/overrun flags.
//  - Register map on the port_id bus:
//      0 R  DATA   buffered byte, read_strobe pops it
//      1 R  STATUS {2'b0, rx_busy, cfg_pending, OVF, FERR, PERR, RXRDY}
//      2 RW CFG    {IRQ_EN, OHEL, PEN, EIGHT, BAUD[3:0]} (read = active)
//      3 W  CMD    bit0 clears error flags, bit1 flushes the buffer
//  - Level interrupt with acknowledge handshake (IDLE / REQ / WAIT).
// Ports:
//   CLK, RESET        clock, synchronous active-high reset
//   bus               processor bus (slave modport)
//   rx_done/rx_data/rx_perr/rx_ferr/rx_busy   from the receive engine
//   EIGHT/PEN/OHEL/BAUD                       active config to the engine
// ---------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter logic [7:0] RESET_CFG = 8'h00
) (
    input  logic                 CLK,
    input  logic                 RESET,
    uart_rx_ctrl_if.slave        bus,
    input  logic                 rx_done,
    input  logic [7:0]           rx_data,
    input  logic                 rx_perr,
    input  logic                 rx_ferr,
    input  logic                 rx_busy,
    output logic                 EIGHT,
    output logic                 PEN,
    output logic                 OHEL,
    output logic [3:0]           BAUD
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } irq_state_t;

    localparam logic [3:0] PORT_DATA   = 4'd0;
    localparam logic [3:0] PORT_STATUS = 4'd1;
    localparam logic [3:0] PORT_CFG    = 4'd2;
    localparam logic [3:0] PORT_CMD    = 4'd3;

    // Configuration state: bit7 (IRQ_EN) lives separately because it bypasses
    // the idle-gated apply path.
    logic [6:0] active_cfg_reg, active_cfg_next;
    logic [6:0] pend_cfg_reg,   pend_cfg_next;
    logic       cfg_pending_reg, cfg_pending_next;
    logic       irq_en_reg,     irq_en_next;

    // Receive buffer and sticky flags
    logic [7:0] buf_reg,   buf_next;
    logic       rxrdy_reg, rxrdy_next;
    logic       perr_reg,  perr_next;
    logic       ferr_reg,  ferr_next;
    logic       ovf_reg,   ovf_next;

    irq_state_t state_reg, state_next;

    // Decoded bus strobes
    logic pop, cfg_wr, cmd_wr, err_clr, flush, load, overrun;

    always_comb begin
        pop     = bus.read_strobe  && (bus.port_id == PORT_DATA);
        cfg_wr  = bus.write_strobe && (bus.port_id == PORT_CFG);
        cmd_wr  = bus.write_strobe && (bus.port_id == PORT_CMD);
        err_clr = cmd_wr && bus.out_port[0];
        flush   = cmd_wr && bus.out_port[1];
        // A new byte is accepted whenever the slot is (or is being) freed;
        // otherwise it is dropped and counted as an overrun.
        load    = rx_done && (!rxrdy_reg || pop || flush);
        overrun = rx_done && !load;
    end

    // Buffer / flag next state. Load is applied after pop/flush and error
    // OR-in after clear, so same-cycle arrivals win.
    always_comb begin
        buf_next   = buf_reg;
        rxrdy_next = rxrdy_reg;
        if (pop || flush) begin
            rxrdy_next = 1'b0;
        end
        if (load) begin
            buf_next   = rx_data;
            rxrdy_next = 1'b1;
        end
        perr_next = (err_clr ? 1'b0 : perr_reg) | (load & rx_perr);
        ferr_next = (err_clr ? 1'b0 : ferr_reg) | (load & rx_ferr);
        ovf_next  = (err_clr ? 1'b0 : ovf_reg)  | overrun;
    end

    // Config next state. A write restarts the pending window, so the earliest
    // apply is the edge after the write.
    always_comb begin
        active_cfg_next  = active_cfg_reg;
        pend_cfg_next    = pend_cfg_reg;
        cfg_pending_next = cfg_pending_reg;
        irq_en_next      = irq_en_reg;
        if (cfg_wr) begin
            pend_cfg_next    = bus.out_port[6:0];
            cfg_pending_next = 1'b1;
            irq_en_next      = bus.out_port[7];
        end else if (cfg_pending_reg && !rx_busy) begin
            active_cfg_next  = pend_cfg_reg;
            cfg_pending_next = 1'b0;
        end
    end

    // Interrupt FSM, driven by the registered RXRDY so the request follows
    // the byte load by one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (rxrdy_reg)          state_next = ST_REQ;
            ST_REQ: begin
                if (!rxrdy_reg)              state_next = ST_IDLE;
                else if (bus.interrupt_ack)  state_next = ST_WAIT;
            end
            ST_WAIT: if (!rxrdy_reg)         state_next = ST_IDLE;
            default:                         state_next = ST_IDLE;
        endcase
        if (!irq_en_reg) begin
            state_next = ST_IDLE;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            active_cfg_reg  <= RESET_CFG[6:0];
            pend_cfg_reg    <= RESET_CFG[6:0];
            cfg_pending_reg <= 1'b0;
            irq_en_reg      <= RESET_CFG[7];
            buf_reg         <= 8'h00;
            rxrdy_reg       <= 1'b0;
            perr_reg        <= 1'b0;
            ferr_reg        <= 1'b0;
            ovf_reg         <= 1'b0;
            state_reg       <= ST_IDLE;
        end else begin
            active_cfg_reg  <= active_cfg_next;
            pend_cfg_reg    <= pend_cfg_next;
            cfg_pending_reg <= cfg_pending_next;
            irq_en_reg      <= irq_en_next;
            buf_reg         <= buf_next;
            rxrdy_reg       <= rxrdy_next;
            perr_reg        <= perr_next;
            ferr_reg        <= ferr_next;
            ovf_reg         <= ovf_next;
            state_reg       <= state_next;
        end
    end

    // Read mux, combinational on port_id
    always_comb begin
        case (bus.port_id)
            PORT_DATA:   bus.in_port = buf_reg;
            PORT_STATUS: bus.in_port = {2'b00, rx_busy, cfg_pending_reg,
                                        ovf_reg, ferr_reg, perr_reg, rxrdy_reg};
            PORT_CFG:    bus.in_port = {irq_en_reg, active_cfg_reg};
            default:     bus.in_port = 8'h00;
        endcase
    end

    assign bus.interrupt = (state_reg == ST_REQ);

    assign OHEL  = active_cfg_reg[6];
    assign PEN   = active_cfg_reg[5];
    assign EIGHT = active_cfg_reg[4];
    assign BAUD  = active_cfg_reg[3:0];

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_ctrl
// Directed bench for uart_rx_ctrl with hand-computed expected values.
// Inputs change 1 time unit after the rising edge; outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_uart_rx_ctrl;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       rx_done;
    logic [7:0] rx_data;
    logic       rx_perr;
    logic       rx_ferr;
    logic       rx_busy;
    logic       EIGHT;
    logic       PEN;
    logic       OHEL;
    logic [3:0] BAUD;

    int n_total = 0;
    int n_pass  = 0;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl #(.RESET_CFG(8'h1B)) dut (
        .CLK     (CLK),
        .RESET   (RESET),
        .bus     (bus),
        .rx_done (rx_done),
        .rx_data (rx_data),
        .rx_perr (rx_perr),
        .rx_ferr (rx_ferr),
        .rx_busy (rx_busy),
        .EIGHT   (EIGHT),
        .PEN     (PEN),
        .OHEL    (OHEL),
        .BAUD    (BAUD)
    );

    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [3:0] p, input logic [7:0] d);
        bus.port_id      = p;
        bus.out_port     = d;
        bus.write_strobe = 1'b1;
        tick();
        bus.write_strobe = 1'b0;
        $display("wr   port %0d data %h", p, d);
    endtask

    task automatic rd(input logic [3:0] p, output logic [7:0] d);
        bus.port_id     = p;
        bus.read_strobe = 1'b1;
        #1;
        d = bus.in_port;
        tick();
        bus.read_strobe = 1'b0;
        $display("rd   port %0d data %h", p, d);
    endtask

    task automatic peek(input logic [3:0] p, output logic [7:0] d);
        bus.port_id = p;
        #1;
        d = bus.in_port;
        $display("peek port %0d data %h", p, d);
    endtask

    task automatic rx_byte(input logic [7:0] d, input logic pe, input logic fe);
        rx_done = 1'b1;
        rx_data = d;
        rx_perr = pe;
        rx_ferr = fe;
        tick();
        rx_done = 1'b0;
        rx_perr = 1'b0;
        rx_ferr = 1'b0;
        $display("rx   data %h perr %0d ferr %0d", d, pe, fe);
    endtask

    logic [7:0] v;

    initial begin
        RESET = 1'b1;
        rx_done = 1'b0; rx_data = 8'h00; rx_perr = 1'b0; rx_ferr = 1'b0; rx_busy = 1'b0;
        bus.port_id = 4'd0; bus.write_strobe = 1'b0; bus.read_strobe = 1'b0;
        bus.out_port = 8'h00; bus.interrupt_ack = 1'b0;
        tick(); tick();
        RESET = 1'b0;

        // Reset state: RESET_CFG = 8'h1B
        check_eq("rst_eight", {7'd0, EIGHT}, 8'h01);
        check_eq("rst_pen",   {7'd0, PEN},   8'h00);
        check_eq("rst_ohel",  {7'd0, OHEL},  8'h00);
        check_eq("rst_baud",  {4'd0, BAUD},  8'h0B);
        check_eq("rst_irq",   {7'd0, bus.interrupt}, 8'h00);
        peek(4'd1, v); check_eq("rst_status", v, 8'h00);
        peek(4'd2, v); check_eq("rst_cfg",    v, 8'h1B);
        peek(4'd0, v); check_eq("rst_data",   v, 8'h00);
        peek(4'd7, v); check_eq("unmapped",   v, 8'h00);

        // CFG 8'h8B while idle: pending for one edge, then applied
        wr(4'd2, 8'h8B);
        peek(4'd1, v); check_eq("cfg_pend", v, 8'h10);
        tick();
        peek(4'd2, v); check_eq("cfg_applied", v, 8'h8B);
        check_eq("cfg_eight", {7'd0, EIGHT}, 8'h00);
        peek(4'd1, v); check_eq("cfg_pend_clr", v, 8'h00);

        // Byte A5 with interrupt handshake
        rx_byte(8'hA5, 1'b0, 1'b0);
        peek(4'd1, v); check_eq("a5_rxrdy", v, 8'h01);
        check_eq("a5_irq_n", {7'd0, bus.interrupt}, 8'h00);
        tick();
        check_eq("a5_irq_n1", {7'd0, bus.interrupt}, 8'h01);
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
        check_eq("a5_ack", {7'd0, bus.interrupt}, 8'h00);
        rd(4'd0, v); check_eq("a5_data", v, 8'hA5);
        peek(4'd1, v); check_eq("a5_popped", v, 8'h00);
        tick();
        check_eq("a5_irq_idle", {7'd0, bus.interrupt}, 8'h00);

        // Overrun: 11 kept, 22 dropped
        rx_byte(8'h11, 1'b0, 1'b0);
        rx_byte(8'h22, 1'b0, 1'b0);
        peek(4'd1, v); check_eq("ovf_status", v, 8'h09);
        peek(4'd0, v); check_eq("ovf_data", v, 8'h11);
        wr(4'd3, 8'h01);
        peek(4'd1, v); check_eq("ovf_clr", v, 8'h01);
        rd(4'd0, v); check_eq("ovf_rd", v, 8'h11);

        // Same-cycle pop of 22 and arrival of 33
        rx_byte(8'h22, 1'b0, 1'b0);
        bus.port_id = 4'd0; bus.read_strobe = 1'b1;
        rx_done = 1'b1; rx_data = 8'h33;
        #1;
        v = bus.in_port;
        tick();
        bus.read_strobe = 1'b0; rx_done = 1'b0;
        $display("rd+rx port 0 data %h new 33", v);
        check_eq("pop_rx_old", v, 8'h22);
        peek(4'd1, v); check_eq("pop_rx_status", v, 8'h01);
        rd(4'd0, v); check_eq("pop_rx_data", v, 8'h33);
        peek(4'd1, v); check_eq("pop_rx_empty", v, 8'h00);

        // CFG 8'h35 while engine busy: held until rx_busy falls
        rx_busy = 1'b1;
        wr(4'd2, 8'h35);
        tick();
        check_eq("busy_baud", {4'd0, BAUD}, 8'h0B);
        peek(4'd1, v); check_eq("busy_status", v, 8'h30);
        rx_busy = 1'b0;
        tick();
        check_eq("idle_baud",  {4'd0, BAUD},  8'h05);
        check_eq("idle_pen",   {7'd0, PEN},   8'h01);
        check_eq("idle_eight", {7'd0, EIGHT}, 8'h01);
        peek(4'd1, v); check_eq("idle_status", v, 8'h00);

        // Error capture, IRQ disabled, flush+clear
        rx_byte(8'h44, 1'b1, 1'b1);
        peek(4'd1, v); check_eq("err_status", v, 8'h07);
        tick();
        check_eq("irq_disabled", {7'd0, bus.interrupt}, 8'h00);
        wr(4'd3, 8'h03);
        peek(4'd1, v); check_eq("flush_clr", v, 8'h00);

        // Flush+clear with simultaneous byte carrying a parity error
        rx_byte(8'h55, 1'b0, 1'b0);
        bus.port_id = 4'd3; bus.out_port = 8'h03; bus.write_strobe = 1'b1;
        rx_done = 1'b1; rx_data = 8'h66; rx_perr = 1'b1;
        tick();
        bus.write_strobe = 1'b0; rx_done = 1'b0; rx_perr = 1'b0;
        $display("wr+rx port 3 data 03 new 66 perr 1");
        peek(4'd1, v); check_eq("flush_rx_status", v, 8'h03);
        peek(4'd0, v); check_eq("flush_rx_data", v, 8'h66);

        // Reset mid-frame with a same-cycle rx_done
        rx_busy = 1'b1; rx_done = 1'b1; rx_data = 8'h77; RESET = 1'b1;
        tick();
        RESET = 1'b0; rx_done = 1'b0; rx_busy = 1'b0;
        $display("reset mid-frame with rx 77");
        peek(4'd1, v); check_eq("rst2_status", v, 8'h00);
        peek(4'd0, v); check_eq("rst2_data", v, 8'h00);
        peek(4'd2, v); check_eq("rst2_cfg", v, 8'h1B);
        check_eq("rst2_baud", {4'd0, BAUD}, 8'h0B);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Control and host-interface block for the UART receive engine. Holds the receiver's configuration (EIGHT, PEN, OHEL, BAUD) and applies changes only while the engine is idle. Buffers each received byte with its error flags, detects overrun, and exposes data and status on the 4-bit port_id / read_strobe / write_strobe processor bus. Generates a level interrupt with an acknowledge handshake.

## Interface
- RESET_CFG, 8'h00: configuration loaded at reset, bit layout as the CFG register.

Ports:
- CLK  in  1  system clock; all logic is on the rising edge.
- RESET  in  1  reset, synchronous and active-high.
- port_id  in  4  processor port address.
- write_strobe  in  1  one-cycle write qualifier.
- read_strobe  in  1  one-cycle read qualifier.
- out_port  in  8  processor write data.
- in_port  out  8  processor read data; combinational mux on port_id.
- interrupt  out  1  interrupt request level.
- interrupt_ack  in  1  one-cycle acknowledge from the processor.
- rx_done  in  1  one-cycle pulse from the engine: a frame is complete.
- rx_data  in  8  received byte; valid when rx_done=1.
- rx_perr  in  1  parity error; valid when rx_done=1.
- rx_ferr  in  1  framing error; valid when rx_done=1.
- rx_busy  in  1  engine is mid-frame (start bit detected, not yet finished).
- EIGHT  out  1  8-bit frame select to the engine.
- PEN  out  1  parity enable to the engine.
- OHEL  out  1  odd/even parity select to the engine.
- BAUD  out  4  baud-rate select to the engine.

## Operation
Register map (other port_id values: in_port=8'h00, writes ignored):
- Port 0, read (DATA): returns the buffered byte. read_strobe pops the buffer (clears RXRDY).
- Port 1, read (STATUS): {2'b0, rx_busy, cfg_pending, OVF, FERR, PERR, RXRDY}. No side effects.
- Port 2, write (CFG): bits {IRQ_EN[7], OHEL[6], PEN[5], EIGHT[4], BAUD[3:0]}. Read at port 2 returns the active config.
- Port 3, write (CMD): bit0 clears PERR, FERR and OVF. bit1 flushes the buffer (RXRDY=0). Both bits may be set together.

Byte capture:
- When rx_done=1 and RXRDY=0: load rx_data and set RXRDY.
- On the same load, OR rx_perr into PERR and rx_ferr into FERR.
- PERR, FERR and OVF are sticky until a CMD bit0 write or reset.
- When rx_done=1 and RXRDY=1 with no same-cycle pop: the new byte is discarded, the buffer keeps the old byte, and OVF is set.
- When rx_done=1 in the same cycle as a DATA pop: the new byte loads, RXRDY stays 1, and OVF is not set.
- When rx_done=1 in the same cycle as a CMD flush: the new byte loads and RXRDY=1 (the load wins).

Configuration apply:
- A CFG write stores the byte in a pending register and sets cfg_pending.
- When cfg_pending=1 and rx_busy=0: active config <= pending and cfg_pending clears. This is evaluated every cycle, so the earliest apply is the cycle after the write.
- A second CFG write while pending overwrites the pending byte.
- IRQ_EN is applied immediately; it does not wait for rx_busy.

Interrupt FSM, states IDLE / REQ / WAIT:
- IDLE -> REQ when RXRDY=1 and IRQ_EN=1. interrupt=1 only in REQ.
- REQ -> WAIT on interrupt_ack.
- REQ -> IDLE if RXRDY clears before the ack (pop or flush).
- WAIT -> IDLE when RXRDY=0. The FSM re-arms for the next byte.
- IRQ_EN=0 forces IDLE from any state.

## Timing
- Reset values: interrupt=0, RXRDY=0, PERR=0, FERR=0, OVF=0, cfg_pending=0, FSM=IDLE, buffer=8'h00.
- On reset, active config = RESET_CFG, so EIGHT, PEN, OHEL and BAUD take the RESET_CFG fields.
- RESET mid-frame: everything returns to reset values. A same-cycle rx_done is ignored.
- Register updates occur at the clock edge where the qualifying strobe or rx_done is high.
- in_port is combinational, valid the same cycle as port_id.
- Latency: rx_done at edge N -> RXRDY=1 after N -> interrupt=1 after N+1 (FSM registered).
- Config latency: 1 cycle after the write if idle; otherwise 1 cycle after rx_busy falls.
- Simultaneous CMD clear and rx_done carrying errors: the new errors win (flags set).

## Test plan
- Reset with RESET_CFG=8'h1B -> EIGHT=1, PEN=0, OHEL=0, BAUD=4'hB; STATUS reads 8'h00; interrupt=0.
- CFG write 8'h8B, then rx_done with rx_data=8'hA5 -> RXRDY=1; interrupt=1 one cycle later; ack -> interrupt=0; DATA read returns 8'hA5; STATUS bit0=0.
- Two rx_done pulses (8'h11 then 8'h22) with no read -> DATA=8'h11 and OVF=1; CMD write 8'h01 -> OVF=0.
- rx_done (8'h33) in the same cycle as the DATA pop of 8'h22 -> RXRDY stays 1, next DATA read returns 8'h33, OVF=0.
- CFG write 8'h35 with rx_busy=1 -> BAUD unchanged and STATUS bit4=1; rx_busy falls -> next edge BAUD=4'h5, PEN=1, EIGHT=1, cfg_pending=0.
- rx_done with rx_perr=1, rx_ferr=1 -> STATUS=8'h07; flush plus clear (CMD 8'h03) -> STATUS=8'h00.
